sparse_row_packer: RTL

- Sits directly upstream of mat_multi. Takes a serial stream of sparse-matrix nonzeros (column index plus complex single-precision value), one per handshake, in row order.
- Packs them into 4-lane beats that match mat_multi's S-port: 4 packed column indices, 4 real/imag pairs, valid/ready.
- Zero-pads the final beat of each row, so no beat ever straddles two rows.
- Tracks the row index and flags the last beat of each row and of each frame.

---
 rtl/mat_pkg.sv | 45 ++++
 rtl/sparse_row_packer_if.sv | 81 ++++++++
 rtl/sparse_beat_reg.sv | 41 ++++
 rtl/sparse_row_packer.sv | 112 +++++++++++
 4 files changed

// File: rtl/mat_pkg.sv
// Shared types for the sparse S-port datapath feeding mat_multi.
// One entry is {col, re, im}; one beat is four lanes plus row metadata.
package mat_pkg;

  localparam int MAT_RANK = 256;
  localparam int LANES    = 4;
  localparam int VAL_W    = 32;

  function automatic int idx_w(input int rank);
    return (rank > 1) ? $clog2(rank) : 1;
  endfunction

  localparam int IDX_W = idx_w(MAT_RANK);

  typedef logic [IDX_W-1:0] idx_t;
  typedef logic [VAL_W-1:0] val_t;

  typedef struct packed {
    idx_t col;
    val_t val_r;
    val_t val_i;
  } entry_t;

  typedef struct packed {
    entry_t [LANES-1:0] lane;
    logic [LANES-1:0]   mask;
    logic               last;
    idx_t               row;
    logic               frame_end;
  } beat_t;

  function automatic logic [LANES-1:0] fill_mask(
    input logic [1:0] cnt
  );
    logic [LANES-1:0] m;
    unique case (cnt)
      2'd0: m = 4'b0001;
      2'd1: m = 4'b0011;
      2'd2: m = 4'b0111;
      2'd3: m = 4'b1111;
    endcase
    return m;
  endfunction

endpackage

// File: rtl/sparse_row_packer_if.sv
// Entry stream in, 4-lane S-port beat out.
// slave is the packer side, master is the producer/consumer side.
interface sparse_row_packer_if #(
  parameter int MAT_RANK = mat_pkg::MAT_RANK
);
  import mat_pkg::*;

  localparam int IDX_W = idx_w(MAT_RANK);

  logic                   in_vld;
  logic                   in_rdy;
  logic [IDX_W-1:0]       in_col;
  logic [VAL_W-1:0]       in_val_r;
  logic [VAL_W-1:0]       in_val_i;
  logic                   in_last;

  logic [IDX_W*LANES-1:0] Scol_index;
  logic [VAL_W-1:0]       S_val_r0;
  logic [VAL_W-1:0]       S_val_r1;
  logic [VAL_W-1:0]       S_val_r2;
  logic [VAL_W-1:0]       S_val_r3;
  logic [VAL_W-1:0]       S_val_i0;
  logic [VAL_W-1:0]       S_val_i1;
  logic [VAL_W-1:0]       S_val_i2;
  logic [VAL_W-1:0]       S_val_i3;
  logic [LANES-1:0]       S_mask;
  logic                   S_last;
  logic [IDX_W-1:0]       S_row;
  logic                   S_frame_end;
  logic                   S_vld_o;
  logic                   S_rdy_o;

  modport slave (
    input  in_vld,
    output in_rdy,
    input  in_col,
    input  in_val_r,
    input  in_val_i,
    input  in_last,
    output Scol_index,
    output S_val_r0,
    output S_val_r1,
    output S_val_r2,
    output S_val_r3,
    output S_val_i0,
    output S_val_i1,
    output S_val_i2,
    output S_val_i3,
    output S_mask,
    output S_last,
    output S_row,
    output S_frame_end,
    output S_vld_o,
    input  S_rdy_o
  );

  modport master (
    output in_vld,
    input  in_rdy,
    output in_col,
    output in_val_r,
    output in_val_i,
    output in_last,
    input  Scol_index,
    input  S_val_r0,
    input  S_val_r1,
    input  S_val_r2,
    input  S_val_r3,
    input  S_val_i0,
    input  S_val_i1,
    input  S_val_i2,
    input  S_val_i3,
    input  S_mask,
    input  S_last,
    input  S_row,
    input  S_frame_end,
    input  S_vld_o,
    output S_rdy_o
  );

endinterface

// File: rtl/sparse_beat_reg.sv
// Single-beat S-port output register with valid/ready hold.
// Reusable by any producer that forms a whole beat in one cycle.
module sparse_beat_reg
  import mat_pkg::*;
(
  input  logic  clk,
  input  logic  rst,
  input  logic  i_load,
  input  beat_t i_beat,
  input  logic  i_rdy,
  output logic  o_vld,
  output beat_t o_beat,
  output logic  o_free
);

  beat_t r_beat;
  logic  r_vld;
  logic  w_free;
  logic  w_take;

  assign w_free = ~r_vld | i_rdy;
  // A load while a beat is stuck would drop data; ignore it.
  assign w_take = i_load & w_free;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_beat <= '0;
      r_vld  <= 1'b0;
    end else if (w_take) begin
      r_beat <= i_beat;
      r_vld  <= 1'b1;
    end else if (i_rdy) begin
      r_vld  <= 1'b0;
    end
  end

  assign o_vld  = r_vld;
  assign o_beat = r_beat;
  assign o_free = w_free;

endmodule

// File: rtl/sparse_row_packer.sv
// Packs row-ordered sparse nonzeros into 4-lane beats for mat_multi.
// Short rows are zero-padded so a beat never spans two rows.
module sparse_row_packer
  import mat_pkg::*;
#(
  parameter int MAT_RANK = mat_pkg::MAT_RANK
) (
  input logic               clk,
  input logic               rst,
  sparse_row_packer_if.slave bus
);

  localparam int IDX_W = idx_w(MAT_RANK);
  localparam logic [IDX_W-1:0] ROW_MAX = IDX_W'(MAT_RANK - 1);

  logic [1:0]       r_rst_sync;
  logic             w_rst;
  logic [1:0]       r_cnt;
  entry_t           r_lane [0:LANES-2];
  logic [IDX_W-1:0] r_row;

  entry_t w_in;
  beat_t  w_beat;
  beat_t  w_q;
  logic   w_vld;
  logic   w_free;
  logic   w_rdy;
  logic   w_acc;
  logic   w_done;

  // Assert immediately, release two clocks after rst drops.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_rst_sync <= 2'b11;
    end else begin
      r_rst_sync <= {r_rst_sync[0], 1'b0};
    end
  end

  assign w_rst = r_rst_sync[1];

  assign w_in.col   = bus.in_col;
  assign w_in.val_r = bus.in_val_r;
  assign w_in.val_i = bus.in_val_i;

  assign w_rdy      = w_free & ~rst;
  assign bus.in_rdy = w_rdy;
  assign w_acc      = bus.in_vld & w_rdy;
  assign w_done     = w_acc & ((r_cnt == 2'd3) | bus.in_last);

  always_comb begin
    w_beat = '0;
    for (int k = 0; k < LANES - 1; k++) begin
      if (k < int'(r_cnt)) begin
        w_beat.lane[k] = r_lane[k];
      end
    end
    w_beat.lane[r_cnt]  = w_in;
    w_beat.mask         = fill_mask(r_cnt);
    w_beat.last         = bus.in_last;
    w_beat.row          = r_row;
    w_beat.frame_end    = bus.in_last & (r_row == ROW_MAX);
  end

  always_ff @(posedge clk or posedge w_rst) begin
    if (w_rst) begin
      r_cnt <= 2'd0;
      r_row <= '0;
      for (int k = 0; k < LANES - 1; k++) begin
        r_lane[k] <= '0;
      end
    end else if (w_acc) begin
      if (w_done) begin
        r_cnt <= 2'd0;
      end else begin
        r_lane[r_cnt] <= w_in;
        r_cnt         <= r_cnt + 2'd1;
      end
      if (bus.in_last) begin
        r_row <= (r_row == ROW_MAX) ? '0 : r_row + 1'b1;
      end
    end
  end

  sparse_beat_reg u_out (
    .clk    (clk),
    .rst    (w_rst),
    .i_load (w_done),
    .i_beat (w_beat),
    .i_rdy  (bus.S_rdy_o),
    .o_vld  (w_vld),
    .o_beat (w_q),
    .o_free (w_free)
  );

  assign bus.Scol_index  = {w_q.lane[3].col, w_q.lane[2].col,
                            w_q.lane[1].col, w_q.lane[0].col};
  assign bus.S_val_r0    = w_q.lane[0].val_r;
  assign bus.S_val_r1    = w_q.lane[1].val_r;
  assign bus.S_val_r2    = w_q.lane[2].val_r;
  assign bus.S_val_r3    = w_q.lane[3].val_r;
  assign bus.S_val_i0    = w_q.lane[0].val_i;
  assign bus.S_val_i1    = w_q.lane[1].val_i;
  assign bus.S_val_i2    = w_q.lane[2].val_i;
  assign bus.S_val_i3    = w_q.lane[3].val_i;
  assign bus.S_mask      = w_q.mask;
  assign bus.S_last      = w_q.last;
  assign bus.S_row       = w_q.row;
  assign bus.S_frame_end = w_q.frame_end;
  assign bus.S_vld_o     = w_vld;

endmodule
